// File: rtl/pcileech_tlp_pkg.sv
// Shared types and constants for the 128-byte TLP connector (66-bit dual-dword slots).
package pcileech_tlp_pkg;

  localparam int TLP128_NUM_QW = 18;
  localparam int TLP_QW_W      = 66;
  localparam int TLP_BIT_LAST  = 64;
  localparam int TLP_BIT_KEEP2 = 65;

  localparam logic [7:0] KEEP_FULL = 8'hFF;
  localparam logic [7:0] KEEP_HALF = 8'h0F;

  typedef enum logic [1:0] {IDLE, WAIT, SEND} tlp_tx_state_t;

  // Only the final beat of a TLP can carry a single dword.
  function automatic logic [7:0] tlp_keep(input logic last, input logic keep2);
    return (last && !keep2) ? KEEP_HALF : KEEP_FULL;
  endfunction

endpackage

// File: rtl/tlp128_axis_tx_stats.sv
// Packet and truncation counters for tlp128_axis_tx (present only with TLP128_AXIS_TX_STATS_EN).
module tlp128_axis_tx_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        last_hs_i,
  input  logic        trunc_hs_i,
  output logic [31:0] tlp_cnt_o,
  output logic [15:0] trunc_cnt_o
);

  logic [31:0] tlp_cnt_q, tlp_cnt_d;
  logic [15:0] trunc_cnt_q, trunc_cnt_d;

  always_comb begin
    tlp_cnt_d   = tlp_cnt_q + 32'(last_hs_i);
    trunc_cnt_d = trunc_cnt_q + 16'(trunc_hs_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tlp_cnt_q   <= '0;
      trunc_cnt_q <= '0;
    end else begin
      tlp_cnt_q   <= tlp_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign tlp_cnt_o   = tlp_cnt_q;
  assign trunc_cnt_o = trunc_cnt_q;

endmodule

// File: rtl/tlp128_axis_tx.sv
// Drains one packed 128-byte TLP into a 64-bit AXI-stream TX port, one slot per beat.
// Optional counters: define TLP128_AXIS_TX_STATS_EN.
module tlp128_axis_tx
  import pcileech_tlp_pkg::*;
#(
  parameter int NUM_QW   = TLP128_NUM_QW,
  parameter int QW_CNT_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TLP_QW_W*NUM_QW-1:0] tlp_data,
  input  logic                       tlp_valid,
  input  logic                       tlp_has_data,
  output logic                       tlp_req_data,
  output logic [63:0]                tx_data,
  output logic [7:0]                 tx_keep,
  output logic                       tx_last,
  output logic                       tx_valid,
  input  logic                       tx_ready
`ifdef TLP128_AXIS_TX_STATS_EN
  ,
  output logic [31:0]                stat_tlp_cnt,
  output logic [15:0]                stat_trunc_cnt
`endif
);

  localparam logic [QW_CNT_W-1:0] LAST_IDX = QW_CNT_W'(NUM_QW - 1);

  tlp_tx_state_t               state_q, state_d;
  logic [QW_CNT_W-1:0]         idx_q, idx_d, nxt_idx;
  logic [TLP_QW_W*NUM_QW-1:0]  buf_q, buf_d;
  logic [TLP_QW_W-1:0]         nxt_slot;
  logic                        nxt_last;
  logic [63:0]                 data_q, data_d;
  logic [7:0]                  keep_q, keep_d;
  logic                        last_q, last_d;
  logic                        valid_q, valid_d;
  logic                        beat_hs;

  assign beat_hs = valid_q & tx_ready;

  // The output registers are preloaded with the slot that follows the current beat,
  // taken straight from tlp_data on capture so the first beat needs no extra cycle.
  always_comb begin
    nxt_idx  = (state_q == SEND && idx_q != LAST_IDX) ? idx_q + 1'b1 : '0;
    nxt_slot = (state_q == WAIT) ? tlp_data[TLP_QW_W-1:0]
                                 : buf_q[32'(nxt_idx) * TLP_QW_W +: TLP_QW_W];
    nxt_last = nxt_slot[TLP_BIT_LAST] | (nxt_idx == LAST_IDX);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: if (tlp_has_data) state_d = WAIT;
      WAIT: begin
        if (tlp_valid) begin
          buf_d   = tlp_data;
          idx_d   = '0;
          valid_d = 1'b1;
          data_d  = nxt_slot[63:0];
          keep_d  = tlp_keep(nxt_last, nxt_slot[TLP_BIT_KEEP2]);
          last_d  = nxt_last;
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat_hs) begin
          if (last_q) begin
            valid_d = 1'b0;
            data_d  = '0;
            keep_d  = '0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d  = nxt_idx;
            data_d = nxt_slot[63:0];
            keep_d = tlp_keep(nxt_last, nxt_slot[TLP_BIT_KEEP2]);
            last_d = nxt_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign tlp_req_data = (state_q == IDLE) & tlp_has_data & ~rst;
  assign tx_data      = data_q;
  assign tx_keep      = keep_q;
  assign tx_last      = last_q;
  assign tx_valid     = valid_q;

`ifdef TLP128_AXIS_TX_STATS_EN
  logic last_hs, trunc_hs;

  assign last_hs  = beat_hs & last_q;
  assign trunc_hs = last_hs & (idx_q == LAST_IDX)
                  & ~buf_q[TLP_QW_W*(NUM_QW-1) + TLP_BIT_LAST];

  tlp128_axis_tx_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .last_hs_i   (last_hs),
    .trunc_hs_i  (trunc_hs),
    .tlp_cnt_o   (stat_tlp_cnt),
    .trunc_cnt_o (stat_trunc_cnt)
  );
`endif

endmodule

// File: tb/tb_tlp128_axis_tx.sv
// Scoreboard bench for tlp128_axis_tx: randomized TLP source, reference beat model, AXI monitor.
`timescale 1ns/1ps
module tb_tlp128_axis_tx;

  localparam int NQ = 18;
  localparam int W  = 66 * NQ;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    int len;
    bit trunc;
    int lk;
  } req_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] tlp_data = '0;
  logic         tlp_valid = 1'b0;
  logic         tlp_has_data = 1'b0;
  logic         tlp_req_data;
  logic [63:0]  tx_data;
  logic [7:0]   tx_keep;
  logic         tx_last;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
`ifdef TLP128_AXIS_TX_STATS_EN
  logic [31:0]  stat_tlp_cnt;
  logic [15:0]  stat_trunc_cnt;
`endif

  tlp128_axis_tx #(.NUM_QW(NQ), .QW_CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .tlp_data     (tlp_data),
    .tlp_valid    (tlp_valid),
    .tlp_has_data (tlp_has_data),
    .tlp_req_data (tlp_req_data),
    .tx_data      (tx_data),
    .tx_keep      (tx_keep),
    .tx_last      (tx_last),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
`ifdef TLP128_AXIS_TX_STATS_EN
    ,
    .stat_tlp_cnt   (stat_tlp_cnt),
    .stat_trunc_cnt (stat_trunc_cnt)
`endif
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  req_t  pend[$];
  bit    rdy_pat[$];
  int    checks = 0, errors = 0;
  int    exp_tlp = 0, exp_trunc = 0;
  int    req_cnt = 0, sent = 0, beats = 0;
  bit    outstanding = 0, rdy_rand = 0, dly_rand = 0;
  int    resp_dly = 1;

  function automatic logic [W-1:0] gen_tlp(input req_t r);
    logic [W-1:0] v;
    logic [65:0]  s;
    v = '0;
    for (int i = 0; i < NQ; i++) begin
      s[63:0]  = {$urandom, $urandom};
      s[65:64] = 2'($urandom);
      if (r.trunc || i < r.len - 1) s[64] = 1'b0;
      else if (i == r.len - 1) begin
        s[64] = 1'b1;
        if (r.lk != 2) s[65] = r.lk[0];
      end
      v[66*i +: 66] = s;
    end
    return v;
  endfunction

  // Expected AXI beats: one per slot up to the first slot flagged last, or the final slot.
  function automatic void model(input logic [W-1:0] v);
    logic [65:0] s;
    beat_t b;
    for (int i = 0; i < NQ; i++) begin
      s   = v[66*i +: 66];
      b.d = s[63:0];
      b.l = s[64] || (i == NQ - 1);
      b.k = (b.l && !s[65]) ? 8'h0F : 8'hFF;
      exp_q.push_back(b);
      if (b.l) begin
        if (!s[64]) exp_trunc++;
        break;
      end
    end
  endfunction

  initial begin : source
    req_t r;
    logic [W-1:0] v;
    int d;
    forever begin
      @(posedge clk); #1;
      tlp_has_data = (pend.size() != 0);
      #1;
      if (!rst && tlp_req_data) begin
        checks++;
        if (outstanding || pend.size() == 0) begin
          errors++;
          $display("FAIL req_discipline: outstanding=%0b pending=%0d, required outstanding=0 pending>0",
                   outstanding, pend.size());
        end
        outstanding = 1;
        req_cnt++;
        if (pend.size() != 0) r = pend.pop_front();
        else r = '{len: 1, trunc: 0, lk: 2};
        d = dly_rand ? int'($urandom_range(1, 4)) : resp_dly;
        @(posedge clk); #1;
        tlp_has_data = (pend.size() != 0);
        repeat (d - 1) begin @(posedge clk); #1; end
        v = gen_tlp(r);
        model(v);
        tlp_data  = v;
        tlp_valid = 1'b1;
        @(posedge clk); #1;
        tlp_valid = 1'b0;
      end
    end
  end

  initial begin : ready_drv
    forever begin
      @(posedge clk); #1;
      if (rdy_pat.size() != 0 && tx_valid) tx_ready = rdy_pat.pop_front();
      else if (rdy_rand) tx_ready = 1'($urandom_range(0, 1));
      else tx_ready = 1'b1;
    end
  end

  initial begin : monitor
    beat_t b;
    bit stall_prev = 0, seen_pkt = 0;
    int idle_run = 0;
    logic [63:0] sd;
    logic [7:0]  sk;
    logic        sl;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_tlp = 0;
        exp_trunc = 0;
        outstanding = 0;
        stall_prev = 0;
        seen_pkt = 0;
        idle_run = 0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (!tx_valid || tx_data !== sd || tx_keep !== sk || tx_last !== sl) begin
            errors++;
            $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b, required v=1 d=%h k=%h l=%b",
                     tx_valid, tx_data, tx_keep, tx_last, sd, sk, sl);
          end
        end
        stall_prev = tx_valid && !tx_ready;
        sd = tx_data; sk = tx_keep; sl = tx_last;
        if (tx_valid) begin
          if (seen_pkt && idle_run > 0) begin
            checks++;
            if (idle_run < 2) begin
              errors++;
              $display("FAIL pkt_gap: got %0d idle cycles, required >=2", idle_run);
            end
          end
          idle_run = 0;
        end else idle_run++;
        if (tx_valid && tx_ready) begin
          beats++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got d=%h k=%h l=%b, required no beat", tx_data, tx_keep, tx_last);
          end else begin
            b = exp_q.pop_front();
            if (tx_data !== b.d || tx_keep !== b.k || tx_last !== b.l) begin
              errors++;
              $display("FAIL beat %0d: got d=%h k=%h l=%b, required d=%h k=%h l=%b",
                       beats, tx_data, tx_keep, tx_last, b.d, b.k, b.l);
            end
            if (b.l) exp_tlp++;
          end
          if (tx_last) begin
            outstanding = 0;
            seen_pkt = 1;
          end
        end
      end
    end
  end

  task automatic send(input int len, input bit trunc, input int lk);
    pend.push_back('{len: len, trunc: trunc, lk: lk});
    sent++;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((pend.size() != 0 || exp_q.size() != 0 || outstanding) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_timeout: pending=%0d expected_beats=%0d, required 0/0", tag, pend.size(), exp_q.size());
      pend.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_stats(input string tag);
`ifdef TLP128_AXIS_TX_STATS_EN
    checks++;
    if (stat_tlp_cnt !== 32'(exp_tlp) || stat_trunc_cnt !== 16'(exp_trunc)) begin
      errors++;
      $display("FAIL %s_stats: got tlp=%0d trunc=%0d, required tlp=%0d trunc=%0d",
               tag, stat_tlp_cnt, stat_trunc_cnt, exp_tlp, exp_trunc);
    end
`else
    if (tag.len() == 0) $display("stats check skipped");
`endif
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tlp_req_data !== 1'b0 || tx_data !== '0 || tx_keep !== '0 || tx_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b req=%b d=%h k=%h l=%b, required all 0",
               tx_valid, tlp_req_data, tx_data, tx_keep, tx_last);
    end
    check_stats("reset");
    @(posedge clk); #1 rst = 1'b0;

    send(2, 0, 0);                 wait_idle("hdr3dw");  check_stats("hdr3dw");
    send(18, 0, 1);                wait_idle("full18");  check_stats("full18");
    send(18, 1, 2);                wait_idle("trunc");   check_stats("trunc");

    rdy_pat = '{1, 0, 0, 1, 0, 1};
    send(4, 0, 2);                 wait_idle("stall4");

    resp_dly = 3;
    for (int i = 0; i < 3; i++) send(int'($urandom_range(1, 6)), 0, 2);
    wait_idle("b2b");
    checks++;
    if (req_cnt != sent) begin
      errors++;
      $display("FAIL b2b_reqs: got %0d requests, required %0d", req_cnt, sent);
    end

    rdy_rand = 1; dly_rand = 1;
    for (int i = 0; i < 25; i++) send(int'($urandom_range(1, 18)), ($urandom_range(0, 7) == 0), 2);
    wait_idle("random");           check_stats("random");

    rdy_rand = 0; dly_rand = 0; resp_dly = 1;
    send(5, 0, 2);
    base = beats; n = 0;
    while (beats < base + 1 && n < 200) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tlp_req_data !== 1'b0 || tx_keep !== '0 || tx_last !== 1'b0) begin
      errors++;
      $display("FAIL midpkt_reset: got v=%b req=%b k=%h l=%b, required all 0",
               tx_valid, tlp_req_data, tx_keep, tx_last);
    end
    check_stats("midpkt_reset");
    send(7, 0, 2);                 wait_idle("post_reset"); check_stats("post_reset");

    checks++;
    if (req_cnt != sent) begin
      errors++;
      $display("FAIL total_reqs: got %0d requests, required %0d", req_cnt, sent);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
